// File: rtl/rename_free_list_if.sv
// Rename free-list port bundle: allocation lanes, commit release lanes,
// checkpoint/restore controls and occupancy status.
interface rename_free_list_if #(
  parameter int PHYS_REGS = 64,
  parameter int NUM_LANES = 2
);
  localparam int RRN_W = $clog2(PHYS_REGS);
  localparam int CNT_W = RRN_W + 1;

  logic [NUM_LANES-1:0]            alloc_req;
  logic [NUM_LANES-1:0][RRN_W-1:0] alloc_rrn;
  logic                            alloc_grant;
  logic [NUM_LANES-1:0]            release_valid;
  logic [NUM_LANES-1:0][RRN_W-1:0] release_rrn;
  logic                            checkpoint;
  logic                            restore;
  logic [CNT_W-1:0]                free_count;
  logic                            empty;
  logic                            overflow;

  modport master (
    output alloc_req, release_valid, release_rrn, checkpoint, restore,
    input  alloc_rrn, alloc_grant, free_count, empty, overflow
  );

  modport slave (
    input  alloc_req, release_valid, release_rrn, checkpoint, restore,
    output alloc_rrn, alloc_grant, free_count, empty, overflow
  );
endinterface

// File: rtl/rename_free_list.sv
// Circular free list of physical register numbers for rename: multi-lane
// all-or-nothing allocate, commit-time release. Define RENAME_FREE_LIST_CHECKPOINT_EN
// to enable the single-snapshot checkpoint/restore of the read pointer.
module rename_free_list_lane #(
  parameter int RRN_W     = 6,
  parameter int NUM_LANES = 2,
  parameter int POS_W     = 1
) (
  input  logic                            req,
  input  logic [POS_W-1:0]                pos,
  input  logic [NUM_LANES-1:0][RRN_W-1:0] offer,
  output logic [RRN_W-1:0]                rrn,
  input  logic                            rel_valid,
  input  logic [RRN_W-1:0]                rel_rrn,
  output logic                            rel_keep
);
  assign rrn      = req ? offer[pos] : '0;
  // rrn 0 is the hardwired zero register and never re-enters the pool
  assign rel_keep = rel_valid && (rel_rrn != '0);
endmodule

module rename_free_list #(
  parameter int PHYS_REGS = 64,
  parameter int ARCH_REGS = 32,
  parameter int NUM_LANES = 2
) (
  input  logic            clock,
  input  logic            reset,
  rename_free_list_if.slave fl
);
  localparam int RRN_W = $clog2(PHYS_REGS);
  localparam int CNT_W = RRN_W + 1;
  localparam int POS_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic [RRN_W-1:0] mem [PHYS_REGS];
  logic [RRN_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] free_count_q;
  logic             overflow_q;

  logic [NUM_LANES-1:0][RRN_W-1:0] offer;
  logic [NUM_LANES-1:0][POS_W-1:0] pos;
  logic [NUM_LANES-1:0]            rel_keep, rel_acc;
  logic [NUM_LANES-1:0][RRN_W-1:0] wr_idx;
  logic [CNT_W-1:0] n_req, n_alloc, fc_after, n_rel, room;
  logic [RRN_W-1:0] rd_ptr_nxt, wr_ptr_nxt;
  logic [CNT_W-1:0] fc_nxt;
  logic             grant_raw, alloc_fire, rel_drop;
  logic             restore_en, ckpt_en;

`ifdef RENAME_FREE_LIST_CHECKPOINT_EN
  logic [RRN_W-1:0] snap_rd, rest_diff;
  logic [CNT_W-1:0] rest_fc;
  assign restore_en = fl.restore;
  assign ckpt_en    = fl.checkpoint && !fl.restore;
`else
  logic unused_ctrl;
  assign unused_ctrl = fl.checkpoint ^ fl.restore;
  assign restore_en  = 1'b0;
  assign ckpt_en     = 1'b0;
`endif

  // Consecutive entries from rd_ptr; requesting lanes pick them in lane order
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign offer[i] = mem[rd_ptr + RRN_W'(i)];
    rename_free_list_lane #(.RRN_W(RRN_W), .NUM_LANES(NUM_LANES), .POS_W(POS_W)) u_lane (
      .req       (fl.alloc_req[i]),
      .pos       (pos[i]),
      .offer     (offer),
      .rrn       (fl.alloc_rrn[i]),
      .rel_valid (fl.release_valid[i]),
      .rel_rrn   (fl.release_rrn[i]),
      .rel_keep  (rel_keep[i])
    );
  end

  always_comb begin
    n_req = '0;
    pos   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      pos[i] = POS_W'(n_req);
      n_req  = n_req + CNT_W'(fl.alloc_req[i]);
    end
  end

  assign grant_raw  = (n_req != '0) && (free_count_q >= n_req);
  assign alloc_fire = grant_raw && !restore_en;
  assign n_alloc    = alloc_fire ? n_req : '0;
  assign fc_after   = free_count_q - n_alloc;

  // Releases are accepted entry-wise while there is room after this cycle's grant
  always_comb begin
    room     = fc_after;
    n_rel    = '0;
    rel_acc  = '0;
    rel_drop = 1'b0;
    wr_idx   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      wr_idx[i] = wr_ptr + n_rel[RRN_W-1:0];
      if (rel_keep[i]) begin
        if (room < CNT_W'(PHYS_REGS)) begin
          rel_acc[i] = 1'b1;
          n_rel      = n_rel + 1'b1;
          room       = room + 1'b1;
        end else begin
          rel_drop = 1'b1;
        end
      end
    end
  end

  assign rd_ptr_nxt = rd_ptr + n_alloc[RRN_W-1:0];
  assign wr_ptr_nxt = wr_ptr + n_rel[RRN_W-1:0];
  assign fc_nxt     = fc_after + n_rel;

`ifdef RENAME_FREE_LIST_CHECKPOINT_EN
  // Equal pointers are ambiguous; rolling back can only add entries, so any
  // nonzero count before the roll back means the ring is completely free.
  assign rest_diff = wr_ptr_nxt - snap_rd;
  assign rest_fc   = (rest_diff != '0) ? {1'b0, rest_diff} :
                     ((free_count_q + n_rel) != '0) ? CNT_W'(PHYS_REGS) : '0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < PHYS_REGS; k++)
        mem[k] <= (k < PHYS_REGS - ARCH_REGS) ? RRN_W'(ARCH_REGS + k) : '0;
      rd_ptr       <= '0;
      wr_ptr       <= RRN_W'(PHYS_REGS - ARCH_REGS);
      free_count_q <= CNT_W'(PHYS_REGS - ARCH_REGS);
      overflow_q   <= 1'b0;
`ifdef RENAME_FREE_LIST_CHECKPOINT_EN
      snap_rd      <= '0;
`endif
    end else begin
      for (int i = 0; i < NUM_LANES; i++)
        if (rel_acc[i]) mem[wr_idx[i]] <= fl.release_rrn[i];
      wr_ptr <= wr_ptr_nxt;
      if (rel_drop) overflow_q <= 1'b1;
`ifdef RENAME_FREE_LIST_CHECKPOINT_EN
      if (restore_en) begin
        rd_ptr       <= snap_rd;
        free_count_q <= rest_fc;
      end else begin
        rd_ptr       <= rd_ptr_nxt;
        free_count_q <= fc_nxt;
      end
      if (ckpt_en) snap_rd <= rd_ptr_nxt;
`else
      rd_ptr       <= rd_ptr_nxt;
      free_count_q <= fc_nxt;
`endif
    end
  end

  assign fl.alloc_grant = alloc_fire;
  assign fl.free_count  = free_count_q;
  assign fl.empty       = (free_count_q == '0);
  assign fl.overflow    = overflow_q;
endmodule

// File: tb/tb_rename_free_list.sv
// Directed bench for rename_free_list: reset image, drain, grant edge cases,
// zero-register release, wrap ordering, overflow, checkpoint/restore.
module tb_rename_free_list;
  logic clock = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  rename_free_list_if #(.PHYS_REGS(64), .NUM_LANES(2)) fl ();

  rename_free_list #(.PHYS_REGS(64), .ARCH_REGS(32), .NUM_LANES(2)) dut (
    .clock (clock),
    .reset (reset),
    .fl    (fl)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    fl.alloc_req     = '0;
    fl.release_valid = '0;
    fl.release_rrn   = '0;
    fl.checkpoint    = 1'b0;
    fl.restore       = 1'b0;
  endtask

  task automatic rel2(input int v, input int a, input int b);
    fl.release_valid  = 2'(v);
    fl.release_rrn[0] = 6'(a);
    fl.release_rrn[1] = 6'(b);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;

    // T1 reset image and offers
    chk("rst_fc", fl.free_count, 32);
    chk("rst_empty", fl.empty, 0);
    chk("rst_ovf", fl.overflow, 0);
    fl.alloc_req = 2'b11; #1;
    chk("t1_rrn0", fl.alloc_rrn[0], 32);
    chk("t1_rrn1", fl.alloc_rrn[1], 33);
    chk("t1_grant", fl.alloc_grant, 1);
    fl.alloc_req = 2'b10; #1;
    chk("t1_l1_only_rrn1", fl.alloc_rrn[1], 32);
    chk("t1_l1_only_rrn0", fl.alloc_rrn[0], 0);

    // T2 drain with both lanes
    for (int c = 0; c < 16; c++) begin
      fl.alloc_req = 2'b11; #1;
      chk("t2_rrn0", fl.alloc_rrn[0], 32 + 2*c);
      chk("t2_rrn1", fl.alloc_rrn[1], 33 + 2*c);
      chk("t2_grant", fl.alloc_grant, 1);
      tick();
    end
    idle(); #1;
    chk("t2_fc0", fl.free_count, 0);
    chk("t2_empty", fl.empty, 1);
    fl.alloc_req = 2'b11; #1;
    chk("t2_grant17", fl.alloc_grant, 0);
    tick();
    chk("t2_fc_hold", fl.free_count, 0);

    // T4 release at empty is not bypassed to a same-cycle request
    fl.alloc_req = 2'b01; rel2(1, 40, 0); #1;
    chk("t4_nogrant", fl.alloc_grant, 0);
    tick(); idle(); #1;
    chk("t4_fc1", fl.free_count, 1);

    // T3 one free, two requests: nothing; then lane 1 alone gets it
    fl.alloc_req = 2'b11; #1;
    chk("t3_grant_both", fl.alloc_grant, 0);
    tick();
    chk("t3_fc_hold", fl.free_count, 1);
    fl.alloc_req = 2'b10; #1;
    chk("t3_rrn1", fl.alloc_rrn[1], 40);
    chk("t3_rrn0", fl.alloc_rrn[0], 0);
    chk("t3_grant_l1", fl.alloc_grant, 1);
    tick(); idle(); #1;
    chk("t3_fc0", fl.free_count, 0);

    // T5 rrn 0 release dropped, 45 kept
    rel2(3, 0, 45);
    tick(); idle(); #1;
    chk("t5_fc", fl.free_count, 1);
    chk("t5_ovf", fl.overflow, 0);
    fl.alloc_req = 2'b01; #1;
    chk("t5_rrn45", fl.alloc_rrn[0], 45);
    tick(); idle(); #1;
    chk("t5_fc0", fl.free_count, 0);

    // 40 releases across the wrap point, drained back in order
    for (int k = 0; k < 20; k++) begin
      rel2(3, 2*k + 1, 2*k + 2);
      tick();
    end
    idle(); #1;
    chk("wrap_fc40", fl.free_count, 40);
    for (int k = 0; k < 20; k++) begin
      fl.alloc_req = 2'b11; #1;
      chk("wrap_rrn0", fl.alloc_rrn[0], 2*k + 1);
      chk("wrap_rrn1", fl.alloc_rrn[1], 2*k + 2);
      tick();
    end
    idle(); #1;
    chk("wrap_fc0", fl.free_count, 0);

    // Same-cycle alloc and release
    rel2(3, 7, 8);
    tick(); idle();
    fl.alloc_req = 2'b11; rel2(1, 9, 0); #1;
    chk("mix_rrn0", fl.alloc_rrn[0], 7);
    chk("mix_rrn1", fl.alloc_rrn[1], 8);
    chk("mix_grant", fl.alloc_grant, 1);
    tick(); idle(); #1;
    chk("mix_fc", fl.free_count, 1);
    fl.alloc_req = 2'b01; #1;
    chk("mix_rrn9", fl.alloc_rrn[0], 9);
    tick(); idle();

    // Fill to PHYS_REGS, then overflow
    for (int k = 0; k < 32; k++) begin
      rel2(3, 11, 12);
      tick();
    end
    idle(); #1;
    chk("full_fc", fl.free_count, 64);
    chk("full_ovf0", fl.overflow, 0);
    rel2(1, 5, 0);
    tick(); idle(); #1;
    chk("ovf_fc", fl.free_count, 64);
    chk("ovf_set", fl.overflow, 1);
    fl.alloc_req = 2'b11; rel2(1, 6, 0);
    tick(); idle(); #1;
    chk("ovf_mix_fc", fl.free_count, 63);
    chk("ovf_sticky", fl.overflow, 1);

    // Reset wins over traffic
    reset = 1'b1; fl.alloc_req = 2'b11; rel2(3, 1, 2);
    tick();
    reset = 1'b0; idle(); #1;
    chk("rst2_fc", fl.free_count, 32);
    chk("rst2_ovf", fl.overflow, 0);

    // T6 checkpoint at fc=30, alloc 6, release 2, restore
    fl.alloc_req = 2'b11;
    tick(); idle();
    fl.checkpoint = 1'b1;
    tick(); idle();
    for (int c = 0; c < 3; c++) begin
      fl.alloc_req = 2'b11; #1;
      chk("t6_rrn0", fl.alloc_rrn[0], 34 + 2*c);
      tick();
    end
    idle(); rel2(3, 34, 35);
    tick(); idle(); #1;
    chk("t6_fc26", fl.free_count, 26);
    fl.restore = 1'b1; fl.alloc_req = 2'b11; #1;
`ifdef RENAME_FREE_LIST_CHECKPOINT_EN
    chk("t6_rest_grant", fl.alloc_grant, 0);
    tick(); idle(); #1;
    chk("t6_rest_fc", fl.free_count, 32);
    fl.alloc_req = 2'b01; #1;
    chk("t6_rest_rrn", fl.alloc_rrn[0], 34);
`else
    chk("t6_noop_grant", fl.alloc_grant, 1);
    tick(); idle(); #1;
    chk("t6_noop_fc", fl.free_count, 24);
    fl.alloc_req = 2'b01; #1;
    chk("t6_noop_rrn", fl.alloc_rrn[0], 42);
`endif
    tick(); idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
